// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg
// Shared types for the UART transmit FIFO/sequencer.
//   tx_state_t : sequencer state (IDLE waits for data, SEND owns the UART)
package uart_tx_fifo_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo_mem.sv
// sync_fifo_mem
// Dual-port register array backing the transmit FIFO.
// Ports:
//   clk   : write clock
//   we    : write enable, stores wdata at waddr on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous, combinational read)
//   rdata : mem[raddr]
// Contents are not reset; the FIFO pointers decide what is valid.
module sync_fifo_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte FIFO plus transmit sequencer sitting directly in front of the UART
// transmitter. Bytes are queued on a single-cycle write strobe and handed to
// the UART one frame at a time, back-to-back while data is available.
// Ports:
//   clk, rst   : system clock (UART 16x baud clock), synchronous active-high reset
//   wr_en      : push wr_data this cycle (dropped if full)
//   wr_data    : byte to queue
//   full/empty : level == depth / level == 0
//   level      : bytes stored, including the byte currently in flight
//   overflow   : sticky, set by a write while full; cleared by clr_ovf
//   clr_ovf    : clear overflow (an overflowing write in the same cycle wins)
//   tx_start   : to UART, request transmission of tx_data
//   tx_data    : to UART, byte in flight, stable for the whole frame
//   tx_done    : from UART, one-cycle pulse when the last data bit completes
//   busy       : sequencer is in SEND
//   state_dbg  : raw sequencer state (0 = IDLE, 1 = SEND)
//
// Handshake: tx_start is a level "valid" that the UART samples at frame start
// and again during its stop state; tx_done is the "accept" pulse that retires
// the in-flight byte. The byte in flight stays in the FIFO (and is counted in
// level) until tx_done pops it, and tx_data only changes on that pop or when
// IDLE launches a new frame. wr_en has no ready: a write while full is lost
// and recorded in overflow.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  clr_ovf,
  output logic                  tx_start,
  output logic [DATA_W-1:0]     tx_data,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  state_dbg
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE_LEVEL  = (DEPTH_LOG2 + 1)'(1);

  tx_state_t               state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]     level_q;
  logic                    overflow_q;
  logic [DATA_W-1:0]       tx_data_q, tx_data_d;
  logic [DEPTH_LOG2-1:0]   raddr;
  logic [DATA_W-1:0]       rdata;
  logic                    push;
  logic                    pop;

  // Fullness is the registered level, so a write in the same cycle as a
  // pop while full is still dropped.
  assign push = wr_en && !full;
  assign pop  = (state_q == ST_SEND) && tx_done;

  sync_fifo_mem #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Next-state logic. In SEND the head byte is already on tx_data, so the
  // read port looks one ahead to have the next byte ready for tx_done.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    raddr     = rd_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (level_q != '0) begin
          tx_data_d = rdata;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        raddr = rd_ptr_q + 1'b1;
        if (tx_done) begin
          if (level_q > ONE_LEVEL) begin
            // Back-to-back: tx_start stays high through the UART stop state.
            tx_data_d = rdata;
          end else begin
            // Last byte retired; a same-cycle write is picked up by IDLE.
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (wr_en && full) begin
        overflow_q <= 1'b1;
      end else if (clr_ovf) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign level     = level_q;
  assign full      = (level_q == FULL_LEVEL);
  assign empty     = (level_q == '0);
  assign overflow  = overflow_q;
  assign busy      = (state_q == ST_SEND);
  assign tx_start  = (state_q == ST_SEND);
  assign tx_data   = tx_data_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Table-driven vectors, directed corner sequences and a randomized run
// against a queue-based reference with a simple UART frame model.
module tb_uart_tx_fifo;

  localparam int DLOG2 = 4;
  localparam int DEPTH = 1 << DLOG2;
  localparam int FRAME = 10;  // shortened data phase of the UART model
  localparam int STOP  = 4;   // stop-state cycles during which tx_start is sampled

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             full, empty, overflow, clr_ovf;
  logic [DLOG2:0]   level;
  logic             tx_start, tx_done, busy, state_dbg;
  logic [7:0]       tx_data;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH_LOG2(DLOG2), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_done   (tx_done),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + UART model ----------------
  logic [7:0] exp_q[$];      // bytes held by the FIFO, head = byte in flight
  logic       ovf_ref;
  bit         model_en = 0;
  int         u_phase;       // 0 idle, 1 data bits, 2 stop
  int         u_cnt;
  int         n_accepted, n_sent;

  task automatic capture(input logic [7:0] d);
    if (exp_q.size() == 0) begin
      check("capture_with_empty_ref", 32'd1, 32'd0);
    end else begin
      check("tx_byte", {24'd0, d}, {24'd0, exp_q[0]});
    end
    n_sent++;
    u_phase = 1;
    u_cnt   = FRAME;
  endtask

  task automatic model_update(input logic pre_start, input logic [7:0] pre_data);
    int sz;
    sz = exp_q.size();
    // FIFO reference: inputs as they were at the edge just taken
    if (tx_done && sz > 0) void'(exp_q.pop_front());
    if (wr_en) begin
      if (sz == DEPTH) ovf_ref = 1'b1;
      else begin
        exp_q.push_back(wr_data);
        n_accepted++;
      end
    end
    if (!(wr_en && sz == DEPTH) && clr_ovf) ovf_ref = 1'b0;
    check("level", {27'd0, level}, exp_q.size());
    check("empty", {31'd0, empty}, {31'd0, exp_q.size() == 0});
    check("full", {31'd0, full}, {31'd0, exp_q.size() == DEPTH});
    check("overflow", {31'd0, overflow}, {31'd0, ovf_ref});
    // UART frame model
    if (tx_done) begin
      tx_done = 1'b0;
      u_phase = 2;
      u_cnt   = STOP;
    end else begin
      case (u_phase)
        0: if (pre_start) capture(pre_data);
        1: begin
          u_cnt--;
          if (u_cnt == 0) tx_done = 1'b1;
        end
        default: begin
          u_cnt--;
          if (u_cnt == 0) begin
            if (pre_start) capture(pre_data);
            else u_phase = 0;
          end
        end
      endcase
    end
  endtask

  // One clock: inputs already driven are sampled at the edge; outputs are
  // read 1 time unit later.
  task automatic tick();
    logic       pre_start;
    logic [7:0] pre_data;
    pre_start = tx_start;
    pre_data  = tx_data;
    @(posedge clk);
    #1;
    if (model_en) model_update(pre_start, pre_data);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    wr_en = 0; wr_data = 0; clr_ovf = 0; tx_done = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en = 1; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic pulse_done();
    tx_done = 1;
    tick();
    tx_done = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic           wr_en;
    logic [7:0]     wr_data;
    logic           clr_ovf;
    logic           tx_done;
    logic [DLOG2:0] level;
    logic           full;
    logic           empty;
    logic           ovf;
    logic           start;
    logic           chk_data;
    logic [7:0]     data;
  } vec_t;

  vec_t vecs[64];
  int   n_vec;

  task automatic add_vec(input logic w, input logic [7:0] wd, input logic c, input logic d,
                         input int lv, input logic ov, input logic st,
                         input logic cd, input logic [7:0] dt);
    vecs[n_vec].wr_en    = w;
    vecs[n_vec].wr_data  = wd;
    vecs[n_vec].clr_ovf  = c;
    vecs[n_vec].tx_done  = d;
    vecs[n_vec].level    = lv[DLOG2:0];
    vecs[n_vec].full     = (lv == DEPTH);
    vecs[n_vec].empty    = (lv == 0);
    vecs[n_vec].ovf      = ov;
    vecs[n_vec].start    = st;
    vecs[n_vec].chk_data = cd;
    vecs[n_vec].data     = dt;
    n_vec++;
  endtask

  // ---------------- test ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         budget;

    // Fill 17 bytes with no tx_done, play with overflow, then drain.
    n_vec = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      add_vec(1, 8'h10 + 8'(i), 0, 0, (i + 1 > DEPTH) ? DEPTH : i + 1,
              i == DEPTH, i >= 1, 1, (i >= 1) ? 8'h10 : 8'h00);
    end
    add_vec(0, 8'h00, 1, 0, DEPTH, 0, 1, 1, 8'h10);  // clr_ovf clears
    add_vec(1, 8'hEE, 1, 0, DEPTH, 1, 1, 1, 8'h10);  // set wins over clear
    add_vec(0, 8'h00, 1, 0, DEPTH, 0, 1, 1, 8'h10);
    for (int k = 1; k < DEPTH; k++) begin
      add_vec(0, 8'h00, 0, 1, DEPTH - k, 0, 1, 1, 8'h10 + 8'(k));
    end
    add_vec(0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00);      // last byte: tx_start drops
    add_vec(0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00);      // tx_done in IDLE ignored

    // Reset values
    do_reset();
    check("rst_tx_start", {31'd0, tx_start}, 0);
    check("rst_tx_data", {24'd0, tx_data}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_level", {27'd0, level}, 0);
    check("rst_empty", {31'd0, empty}, 1);
    check("rst_full", {31'd0, full}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    check("rst_state", {31'd0, state_dbg}, 0);

    // Single byte 0x55: tx_start/tx_data valid two edges after the write
    write_byte(8'h55);
    check("one_level", {27'd0, level}, 1);
    check("one_start_early", {31'd0, tx_start}, 0);
    tick();
    check("one_start", {31'd0, tx_start}, 1);
    check("one_data", {24'd0, tx_data}, 8'h55);
    check("one_busy", {31'd0, busy}, 1);
    check("one_state", {31'd0, state_dbg}, 1);
    tick();
    check("one_hold", {24'd0, tx_data}, 8'h55);
    pulse_done();
    check("one_done_start", {31'd0, tx_start}, 0);
    check("one_done_empty", {31'd0, empty}, 1);
    check("one_done_level", {27'd0, level}, 0);

    // Three consecutive writes, back-to-back frames
    do_reset();
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    check("b2b_level", {27'd0, level}, 3);
    check("b2b_d1", {24'd0, tx_data}, 8'h01);
    tick();
    check("b2b_d1_hold", {24'd0, tx_data}, 8'h01);
    pulse_done();
    check("b2b_d2", {24'd0, tx_data}, 8'h02);
    check("b2b_start2", {31'd0, tx_start}, 1);
    check("b2b_level2", {27'd0, level}, 2);
    pulse_done();
    check("b2b_d3", {24'd0, tx_data}, 8'h03);
    check("b2b_start3", {31'd0, tx_start}, 1);
    pulse_done();
    check("b2b_end_start", {31'd0, tx_start}, 0);
    check("b2b_end_level", {27'd0, level}, 0);

    // Vector table
    do_reset();
    for (int i = 0; i < n_vec; i++) begin
      wr_en = vecs[i].wr_en; wr_data = vecs[i].wr_data;
      clr_ovf = vecs[i].clr_ovf; tx_done = vecs[i].tx_done;
      tick();
      idle_inputs();
      check($sformatf("vec%0d_level", i), {27'd0, level}, {27'd0, vecs[i].level});
      check($sformatf("vec%0d_full", i), {31'd0, full}, {31'd0, vecs[i].full});
      check($sformatf("vec%0d_empty", i), {31'd0, empty}, {31'd0, vecs[i].empty});
      check($sformatf("vec%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].ovf});
      check($sformatf("vec%0d_start", i), {31'd0, tx_start}, {31'd0, vecs[i].start});
      if (vecs[i].chk_data)
        check($sformatf("vec%0d_data", i), {24'd0, tx_data}, {24'd0, vecs[i].data});
    end

    // Last byte in SEND with a same-cycle write of 0xA7
    do_reset();
    write_byte(8'hA0);
    tick();
    check("l1_start", {31'd0, tx_start}, 1);
    wr_en = 1; wr_data = 8'hA7; tx_done = 1;
    tick();
    idle_inputs();
    check("l1_level", {27'd0, level}, 1);
    check("l1_gap", {31'd0, tx_start}, 0);
    tick();
    check("l1_restart", {31'd0, tx_start}, 1);
    check("l1_data", {24'd0, tx_data}, 8'hA7);
    pulse_done();
    check("l1_final_empty", {31'd0, empty}, 1);

    // Full with write and tx_done in the same cycle
    do_reset();
    for (int i = 0; i < DEPTH; i++) write_byte(8'h80 + 8'(i));
    check("fd_full", {31'd0, full}, 1);
    wr_en = 1; wr_data = 8'hFF; tx_done = 1;
    tick();
    idle_inputs();
    check("fd_level", {27'd0, level}, DEPTH - 1);
    check("fd_ovf", {31'd0, overflow}, 1);
    check("fd_data", {24'd0, tx_data}, 8'h81);

    // Reset mid-frame with 5 bytes queued
    do_reset();
    for (int i = 0; i < 5; i++) write_byte(8'hC0 + 8'(i));
    check("mr_busy", {31'd0, busy}, 1);
    rst = 1;
    tick();
    rst = 0;
    check("mr_level", {27'd0, level}, 0);
    check("mr_start", {31'd0, tx_start}, 0);
    check("mr_data", {24'd0, tx_data}, 0);
    check("mr_ovf", {31'd0, overflow}, 0);
    check("mr_empty", {31'd0, empty}, 1);

    // Randomized run against the reference and UART model
    do_reset();
    exp_q.delete();
    ovf_ref = 0; u_phase = 0; u_cnt = 0; n_accepted = 0; n_sent = 0;
    model_en = 1;
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom_range(0, 99) < ((i < 1500) ? 30 : 5));
      b       = 8'($urandom_range(0, 255));
      wr_data = b;
      clr_ovf = ($urandom_range(0, 99) < 2);
      tick();
    end
    wr_en = 0; clr_ovf = 0;
    budget = 5000;
    while ((exp_q.size() != 0 || u_phase != 0) && budget > 0) begin
      tick();
      budget--;
    end
    check("drain_timeout", {31'd0, budget == 0}, 0);
    check("sent_vs_accepted", n_sent, n_accepted);
    model_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
